// File: rtl/nibble_serial_adder_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// nibble_serial_adder_pkg : FSM encoding and slice width for the serial adder
// Revision: 1.0
// ---------------------------------------------------------------------------
package nibble_serial_adder_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/nibble_serial_adder_rca.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ripple_carry_adder_4_cin : combinational 4-bit ripple-carry slice with cin
// Revision: 1.0
// ---------------------------------------------------------------------------
module ripple_carry_adder_4_cin (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);

  logic [4:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < 4; i++) begin : g_bit
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[4];

endmodule
`default_nettype wire

// File: rtl/nibble_serial_adder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// nibble_serial_adder : WIDTH-bit adder reusing one 4-bit slice, LS nibble first
// Revision: 1.0
// ---------------------------------------------------------------------------
module nibble_serial_adder
  import nibble_serial_adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] sum_out,
  output logic             cout_out,
  output logic             ovf_out,
  output logic             busy
);

  localparam int NIBBLES = WIDTH / NIBBLE_W;
  localparam int IDX_W   = $clog2(NIBBLES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               carry_q, carry_d;
  logic [WIDTH-1:0]   psum_q, psum_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;

  logic [NIBBLE_W-1:0] slice_a;
  logic [NIBBLE_W-1:0] slice_b;
  logic [NIBBLE_W-1:0] slice_s;
  logic                slice_cout;

  assign slice_a = a_q[idx_q*NIBBLE_W +: NIBBLE_W];
  assign slice_b = b_q[idx_q*NIBBLE_W +: NIBBLE_W];

  ripple_carry_adder_4_cin u_slice (
    .a    (slice_a),
    .b    (slice_b),
    .cin  (carry_q),
    .s    (slice_s),
    .cout (slice_cout)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    psum_d  = psum_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    case (state_q)
      ST_IDLE: begin
        if (start_valid) begin
          a_d     = a_in;
          b_d     = b_in;
          carry_d = cin;
          idx_d   = '0;
          psum_d  = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        psum_d[idx_q*NIBBLE_W +: NIBBLE_W] = slice_s;
        carry_d = slice_cout;
        if (idx_q == LAST_IDX) begin
          // psum_d already holds the top nibble, so the outputs see the full sum now
          idx_d   = '0;
          sum_d   = psum_d;
          cout_d  = slice_cout;
          ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (psum_d[WIDTH-1] != a_q[WIDTH-1]);
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      ST_DONE: begin
        if (res_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      psum_q  <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      psum_q  <= psum_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign start_ready = (state_q == ST_IDLE);
  assign res_valid   = (state_q == ST_DONE);
  assign busy        = (state_q == ST_RUN) || (state_q == ST_DONE);
  assign sum_out     = sum_q;
  assign cout_out    = cout_q;
  assign ovf_out     = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_nibble_serial_adder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_nibble_serial_adder : directed and random checks against an arithmetic model
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_nibble_serial_adder;

  localparam int WIDTH   = 16;
  localparam int NIBBLES = WIDTH / 4;

  logic             clk;
  logic             rst_n;
  logic             start_valid;
  logic             start_ready;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             cin;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] sum_out;
  logic             cout_out;
  logic             ovf_out;
  logic             busy;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  nibble_serial_adder #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .a_in        (a_in),
    .b_in        (b_in),
    .cin         (cin),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .sum_out     (sum_out),
    .cout_out    (cout_out),
    .ovf_out     (ovf_out),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Called at a negedge with the DUT idle. poke drives junk on the operand side while busy.
  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic c, input int stall, input bit poke);
    logic [WIDTH:0]   full;
    logic [WIDTH-1:0] exp_sum;
    logic             exp_cout;
    logic             exp_ovf;
    int               lat;

    full     = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c};
    exp_sum  = full[WIDTH-1:0];
    exp_cout = full[WIDTH];
    exp_ovf  = (a[WIDTH-1] == b[WIDTH-1]) && (exp_sum[WIDTH-1] != a[WIDTH-1]);

    check("start_ready_idle", start_ready, 1);
    start_valid = 1'b1;
    a_in        = a;
    b_in        = b;
    cin         = c;
    res_ready   = 1'b0;
    tick();
    start_valid = 1'b0;
    if (poke) begin
      cin = ~c;
      a_in = WIDTH'($urandom);
      b_in = WIDTH'($urandom);
    end

    lat = 0;
    while (!res_valid && lat < 3 * NIBBLES) begin
      if (lat == 0) check("busy_in_run", busy, 1);
      tick();
      lat++;
      if (poke) begin
        start_valid = 1'($urandom);
        a_in        = WIDTH'($urandom);
        b_in        = WIDTH'($urandom);
        cin         = 1'($urandom);
      end
    end
    check("latency", lat, NIBBLES);
    check("res_valid", res_valid, 1);
    check("sum", sum_out, exp_sum);
    check("cout", cout_out, exp_cout);
    check("ovf", ovf_out, exp_ovf);
    check("start_ready_done", start_ready, 0);

    for (int i = 0; i < stall; i++) begin
      tick();
      if (poke) begin
        start_valid = 1'($urandom);
        a_in        = WIDTH'($urandom);
      end
      check("stall_valid", res_valid, 1);
      check("stall_sum", sum_out, exp_sum);
      check("stall_busy", busy, 1);
    end

    // An offered operand on the handshake edge must not be accepted.
    res_ready   = 1'b1;
    start_valid = poke;
    tick();
    start_valid = 1'b0;
    res_ready   = 1'b0;
    check("post_hs_valid", res_valid, 0);
    check("post_hs_ready", start_ready, 1);
    check("post_hs_busy", busy, 0);
    check("kept_sum", sum_out, exp_sum);
    check("kept_cout", cout_out, exp_cout);
  endtask

  initial begin
    rst_n       = 1'b0;
    start_valid = 1'b0;
    a_in        = '0;
    b_in        = '0;
    cin         = 1'b0;
    res_ready   = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    check("rst_sum", sum_out, 0);
    check("rst_cout", cout_out, 0);
    check("rst_ovf", ovf_out, 0);
    check("rst_valid", res_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", start_ready, 1);

    run_op(16'h1234, 16'h4321, 1'b0, 0, 1'b0);
    run_op(16'hFFFF, 16'h0001, 1'b0, 0, 1'b0);
    run_op(16'h7FFF, 16'h0001, 1'b0, 0, 1'b0);
    run_op(16'h8000, 16'h8000, 1'b0, 0, 1'b0);
    run_op(16'h0000, 16'hFFFF, 1'b1, 0, 1'b1);
    run_op(16'hA5A5, 16'h5A5B, 1'b0, 10, 1'b1);
    run_op(16'h0102, 16'h0304, 1'b0, 0, 1'b0);

    // Abort mid-RUN after two slice cycles
    start_valid = 1'b1;
    a_in        = 16'hFFFF;
    b_in        = 16'hFFFF;
    cin         = 1'b1;
    tick();
    start_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("abort_sum", sum_out, 0);
    check("abort_cout", cout_out, 0);
    check("abort_ovf", ovf_out, 0);
    check("abort_valid", res_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_ready", start_ready, 1);
    run_op(16'h00FF, 16'h0001, 1'b0, 0, 1'b0);

    for (int n = 0; n < 200; n++) begin
      run_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom),
             int'($urandom_range(0, 3)), 1'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
